// File: rtl/ship_life_ctrl.sv
// Player ship life sequencer: lives, explode/respawn/invulnerability timing,
// recentre pulse, thrust/fire gating and sprite enables.
module ship_life_ctrl #(
    parameter int LIVES          = 3,
    parameter int EXPLODE_FRAMES = 60,
    parameter int RESPAWN_FRAMES = 30,
    parameter int INVULN_FRAMES  = 120,
    parameter int BLINK_SHIFT    = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       hit,
    input  logic       thrust_btn,
    input  logic       fire_btn,
    output logic       ship_reset,
    output logic       thrust_en,
    output logic       fire_en,
    output logic       ship_visible,
    output logic       explode_active,
    output logic [3:0] lives,
    output logic       game_over
);

    localparam int TMAX0 = (EXPLODE_FRAMES > RESPAWN_FRAMES) ?
                           EXPLODE_FRAMES : RESPAWN_FRAMES;
    localparam int TMAX  = (TMAX0 > INVULN_FRAMES) ? TMAX0 : INVULN_FRAMES;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_EXP = TW'(EXPLODE_FRAMES);
    localparam logic [TW-1:0] T_RSP = TW'(RESPAWN_FRAMES);
    localparam logic [TW-1:0] T_INV = TW'(INVULN_FRAMES);
    localparam logic [TW-1:0] T_ONE = TW'(1);

    localparam logic [BLINK_SHIFT:0] B_ONE = (BLINK_SHIFT+1)'(1);
    localparam logic [3:0]           L_INIT = 4'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INVULN,
        S_ALIVE,
        S_EXPLODE,
        S_RESPAWN,
        S_GAMEOVER
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [BLINK_SHIFT:0] blink_cnt;
    logic                last_tick;

    // The tick that takes the timer 1->0 is the one that leaves the state.
    assign last_tick = frame_tick && (timer <= T_ONE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_IDLE;
            lives      <= 4'd0;
            timer      <= '0;
            blink_cnt  <= '0;
            ship_reset <= 1'b0;
        end else begin
            ship_reset <= 1'b0;
            unique case (state)
                S_IDLE, S_GAMEOVER: begin
                    if (start) begin
                        state      <= S_INVULN;
                        lives      <= L_INIT;
                        timer      <= T_INV;
                        blink_cnt  <= '0;
                        ship_reset <= 1'b1;
                    end
                end
                S_INVULN: begin
                    if (frame_tick) begin
                        blink_cnt <= blink_cnt + B_ONE;
                        if (last_tick) begin
                            state <= S_ALIVE;
                            timer <= '0;
                        end else begin
                            timer <= timer - T_ONE;
                        end
                    end
                end
                S_ALIVE: begin
                    if (hit) begin
                        state <= S_EXPLODE;
                        lives <= lives - 4'd1;
                        timer <= T_EXP;
                    end
                end
                S_EXPLODE: begin
                    if (last_tick) begin
                        if (lives == 4'd0) begin
                            state <= S_GAMEOVER;
                            timer <= '0;
                        end else begin
                            state      <= S_RESPAWN;
                            timer      <= T_RSP;
                            ship_reset <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        timer <= timer - T_ONE;
                    end
                end
                S_RESPAWN: begin
                    if (last_tick) begin
                        state     <= S_INVULN;
                        timer     <= T_INV;
                        blink_cnt <= '0;
                    end else if (frame_tick) begin
                        timer <= timer - T_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic can_act;
    assign can_act        = (state == S_ALIVE) || (state == S_INVULN);
    assign thrust_en      = thrust_btn & can_act;
    assign fire_en        = fire_btn & can_act;
    assign ship_visible   = (state == S_ALIVE) ||
                            ((state == S_INVULN) && !blink_cnt[BLINK_SHIFT]);
    assign explode_active = (state == S_EXPLODE);
    assign game_over      = (state == S_GAMEOVER);

endmodule

// File: tb/tb_ship_life_ctrl.sv
// Bench for ship_life_ctrl: vector table, corner sequences and random
// stimulus checked against a phase/elapsed-tick model.
module tb_ship_life_ctrl;

    localparam int LV  = 3;
    localparam int EXN = 4;
    localparam int RSN = 2;
    localparam int INN = 8;
    localparam int BS  = 1;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       thrust_btn = 1'b0;
    logic       fire_btn = 1'b0;
    logic       ship_reset;
    logic       thrust_en;
    logic       fire_en;
    logic       ship_visible;
    logic       explode_active;
    logic [3:0] lives;
    logic       game_over;

    ship_life_ctrl #(
        .LIVES(LV), .EXPLODE_FRAMES(EXN), .RESPAWN_FRAMES(RSN),
        .INVULN_FRAMES(INN), .BLINK_SHIFT(BS)
    ) dut (
        .clk(clk), .resetN(resetN), .frame_tick(frame_tick),
        .start(start), .hit(hit), .thrust_btn(thrust_btn),
        .fire_btn(fire_btn), .ship_reset(ship_reset),
        .thrust_en(thrust_en), .fire_en(fire_en),
        .ship_visible(ship_visible), .explode_active(explode_active),
        .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: game phase, frame ticks elapsed in it, lives, recentre pulse.
    typedef enum int {M_IDLE, M_INV, M_ALIVE, M_EXP, M_RSP, M_GO} ph_t;
    ph_t m_ph = M_IDLE;
    int  m_cnt = 0;
    int  m_lives = 0;
    bit  m_sr = 1'b0;

    task automatic model_reset();
        m_ph = M_IDLE; m_cnt = 0; m_lives = 0; m_sr = 1'b0;
    endtask

    task automatic model_clk(input bit st, input bit ht, input bit ft);
        m_sr = 1'b0;
        case (m_ph)
            M_IDLE, M_GO: if (st) begin
                m_ph = M_INV; m_cnt = 0; m_lives = LV; m_sr = 1'b1;
            end
            M_INV: if (ft) begin
                m_cnt++;
                if (m_cnt == INN) begin m_ph = M_ALIVE; m_cnt = 0; end
            end
            M_ALIVE: if (ht) begin
                m_ph = M_EXP; m_cnt = 0; m_lives--;
            end
            M_EXP: if (ft) begin
                m_cnt++;
                if (m_cnt == EXN) begin
                    m_cnt = 0;
                    if (m_lives == 0) m_ph = M_GO;
                    else begin m_ph = M_RSP; m_sr = 1'b1; end
                end
            end
            M_RSP: if (ft) begin
                m_cnt++;
                if (m_cnt == RSN) begin m_ph = M_INV; m_cnt = 0; end
            end
            default: m_ph = M_IDLE;
        endcase
    endtask

    task automatic model_check();
        bit act, vis;
        act = (m_ph == M_ALIVE) || (m_ph == M_INV);
        vis = (m_ph == M_ALIVE) ||
              ((m_ph == M_INV) && (((m_cnt >> BS) & 1) == 0));
        chk("m_ship_reset", 8'(ship_reset), 8'(m_sr));
        chk("m_thrust_en", 8'(thrust_en), 8'(thrust_btn & act));
        chk("m_fire_en", 8'(fire_en), 8'(fire_btn & act));
        chk("m_visible", 8'(ship_visible), 8'(vis));
        chk("m_explode", 8'(explode_active), 8'(m_ph == M_EXP));
        chk("m_game_over", 8'(game_over), 8'(m_ph == M_GO));
        chk("m_lives", 8'(lives), 8'(m_lives));
    endtask

    task automatic step(input bit st, input bit ht, input bit ft,
                        input bit th, input bit fi);
        start = st; hit = ht; frame_tick = ft;
        thrust_btn = th; fire_btn = fi;
        @(posedge clk);
        model_clk(st, ht, ft);
        #1;
        model_check();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit st, ht, ft, th, fi;
        bit sr, vis, ex, ten, fen, go;
        logic [3:0] lv;
    } vec_t;

    vec_t vt[17];

    initial begin
        vt[0]  = '{1,0,0,1,0, 1,1,0,1,0,0, 4'd3};
        vt[1]  = '{0,0,1,1,1, 0,1,0,1,1,0, 4'd3};
        vt[2]  = '{0,1,1,1,0, 0,0,0,1,0,0, 4'd3};
        vt[3]  = '{0,1,0,1,0, 0,0,0,1,0,0, 4'd3};
        vt[4]  = '{0,0,1,1,0, 0,0,0,1,0,0, 4'd3};
        vt[5]  = '{0,0,1,1,0, 0,1,0,1,0,0, 4'd3};
        vt[6]  = '{0,0,1,1,0, 0,1,0,1,0,0, 4'd3};
        vt[7]  = '{0,0,1,1,0, 0,0,0,1,0,0, 4'd3};
        vt[8]  = '{0,0,1,1,0, 0,0,0,1,0,0, 4'd3};
        vt[9]  = '{0,0,1,1,1, 0,1,0,1,1,0, 4'd3};
        vt[10] = '{0,1,1,1,1, 0,0,1,0,0,0, 4'd2};
        vt[11] = '{0,0,1,1,0, 0,0,1,0,0,0, 4'd2};
        vt[12] = '{0,0,1,1,0, 0,0,1,0,0,0, 4'd2};
        vt[13] = '{0,0,1,1,0, 0,0,1,0,0,0, 4'd2};
        vt[14] = '{0,0,1,1,0, 1,0,0,0,0,0, 4'd2};
        vt[15] = '{0,0,1,1,0, 0,0,0,0,0,0, 4'd2};
        vt[16] = '{1,0,1,1,0, 0,1,0,1,0,0, 4'd2};

        thrust_btn = 1'b1; fire_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ship_reset", 8'(ship_reset), 8'd0);
        chk("rst_thrust_en", 8'(thrust_en), 8'd0);
        chk("rst_fire_en", 8'(fire_en), 8'd0);
        chk("rst_visible", 8'(ship_visible), 8'd0);
        chk("rst_lives", 8'(lives), 8'd0);
        chk("rst_game_over", 8'(game_over), 8'd0);
        resetN = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 17; i++) begin
            step(vt[i].st, vt[i].ht, vt[i].ft, vt[i].th, vt[i].fi);
            chk($sformatf("v%0d_ship_reset", i), 8'(ship_reset), 8'(vt[i].sr));
            chk($sformatf("v%0d_visible", i), 8'(ship_visible), 8'(vt[i].vis));
            chk($sformatf("v%0d_explode", i), 8'(explode_active), 8'(vt[i].ex));
            chk($sformatf("v%0d_thrust_en", i), 8'(thrust_en), 8'(vt[i].ten));
            chk($sformatf("v%0d_fire_en", i), 8'(fire_en), 8'(vt[i].fen));
            chk($sformatf("v%0d_game_over", i), 8'(game_over), 8'(vt[i].go));
            chk($sformatf("v%0d_lives", i), 8'(lives), 8'(vt[i].lv));
        end

        // Burn the remaining two lives down to game over.
        ticks(INN);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("go_lives1", 8'(lives), 8'd1);
        ticks(EXN);
        chk("go_rsp_pulse", 8'(ship_reset), 8'd1);
        ticks(RSN + INN);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("go_lives0", 8'(lives), 8'd0);
        ticks(EXN - 1);
        chk("go_still_exp", 8'(explode_active), 8'd1);
        ticks(1);
        chk("go_game_over", 8'(game_over), 8'd1);
        chk("go_no_pulse", 8'(ship_reset), 8'd0);
        chk("go_lives", 8'(lives), 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("go_hold", 8'(game_over), 8'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_lives", 8'(lives), 8'd3);
        chk("restart_pulse", 8'(ship_reset), 8'd1);
        chk("restart_go", 8'(game_over), 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_pulse_once", 8'(ship_reset), 8'd0);

        // Async reset in EXPLODE with two ticks left.
        ticks(INN);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        thrust_btn = 1'b1; fire_btn = 1'b1;
        #2 resetN = 1'b0;
        #1;
        model_reset();
        chk("arst_explode", 8'(explode_active), 8'd0);
        chk("arst_lives", 8'(lives), 8'd0);
        chk("arst_thrust", 8'(thrust_en), 8'd0);
        chk("arst_fire", 8'(fire_en), 8'd0);
        chk("arst_visible", 8'(ship_visible), 8'd0);
        chk("arst_pulse", 8'(ship_reset), 8'd0);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("arst_after_pulse", 8'(ship_reset), 8'd0);

        // Frame tick gap in EXPLODE: timer must hold.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(INN);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        ticks(EXN - 2);
        chk("gap_still_exp", 8'(explode_active), 8'd1);
        ticks(1);
        chk("gap_rsp_pulse", 8'(ship_reset), 8'd1);

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                resetN = 1'b0;
                @(posedge clk);
                model_reset();
                #1;
                model_check();
                resetN = 1'b1;
            end else begin
                step(($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 2) == 0),
                     1'($urandom), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ship_life_ctrl.md
Name: ship_life_ctrl

Overview:
- Game-level sequencer for the player ship. Sits between the collision detector, the player buttons and the ship movement block.
- Owns the lives counter and the explode, respawn and invulnerability timing.
- Issues the one-cycle recentre/stop pulse that drives the movement block's collision input.
- Gates thrust and fire, and drives ship visibility (blink) and the explosion sprite enable.

Parameters:
LIVES, 3, lives loaded on game start (1..15)
EXPLODE_FRAMES, 60, frame ticks spent in EXPLODE
RESPAWN_FRAMES, 30, frame ticks ship stays hidden before reappearing
INVULN_FRAMES, 120, frame ticks of invulnerability after (re)spawn
BLINK_SHIFT, 3, blink period during INVULN = 2^(BLINK_SHIFT+1) frame ticks

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  game start button (level, sampled each cycle)
hit  in  1  raw ship/asteroid collision (level)
thrust_btn  in  1  raw thrust button
fire_btn  in  1  raw fire button
ship_reset  out  1  one-cycle pulse: recentre and zero ship speed
thrust_en  out  1  gated thrust to movement block
fire_en  out  1  gated fire to missile block
ship_visible  out  1  ship sprite enable
explode_active  out  1  explosion sprite enable
lives  out  4  remaining lives
game_over  out  1  high in GAMEOVER state

Behaviour:
- States: IDLE, INVULN, ALIVE, EXPLODE, RESPAWN, GAMEOVER. All are registered.
- Reset (async, resetN=0): state=IDLE, lives=0, timer=0, blink_cnt=0, ship_reset=0.
  - All outputs are 0 during and immediately after reset.
  - Reset mid-operation aborts any timer. There is no pending pulse afterwards.
- Timer width is $clog2(max(EXPLODE_FRAMES,RESPAWN_FRAMES,INVULN_FRAMES)+1).
  - On entry to a timed state the timer loads that state's N.
  - Each frame_tick decrements it.
  - The state exits at the clock edge of the frame_tick that takes the timer 1->0. Dwell is therefore exactly N frame ticks.
  - Cycles without frame_tick hold the timer.
- IDLE or GAMEOVER with start=1 goes to INVULN. On that edge:
  - lives<=LIVES;
  - timer<=INVULN_FRAMES;
  - blink_cnt<=0;
  - ship_reset<=1.
- INVULN:
  - hit is ignored.
  - blink_cnt increments on each frame_tick.
  - On expiry, go to ALIVE.
- ALIVE with hit=1 goes to EXPLODE. On that edge:
  - lives<=lives-1;
  - timer<=EXPLODE_FRAMES.
  - hit has priority over a coincident frame_tick.
- EXPLODE expiry:
  - If lives==0, go to GAMEOVER.
  - Otherwise go to RESPAWN, with timer<=RESPAWN_FRAMES and ship_reset<=1.
- RESPAWN expiry goes to INVULN, with timer<=INVULN_FRAMES and blink_cnt<=0.
- GAMEOVER holds until start. lives stays 0.
- hit is sampled only in ALIVE. It is ignored in every other state, so lives can never underflow.
- ship_reset:
  - Registered. High exactly during the first cycle of the entered state (INVULN from start, or RESPAWN). Low otherwise.
  - Never high for 2 consecutive cycles.
- Combinational outputs, decoded from registered state:
  - thrust_en = thrust_btn & (ALIVE|INVULN).
  - fire_en = fire_btn & (ALIVE|INVULN).
  - ship_visible = ALIVE | (INVULN & ~blink_cnt[BLINK_SHIFT]). The ship is visible first, then blinks.
  - explode_active = EXPLODE.
  - game_over = GAMEOVER.
- start held high while not in IDLE/GAMEOVER has no effect. Holding it through GAMEOVER restarts on the first GAMEOVER cycle.
- blink_cnt is BLINK_SHIFT+1 bits and wraps freely.

Test Plan:
(Use EXPLODE_FRAMES=4, RESPAWN_FRAMES=2, INVULN_FRAMES=8, BLINK_SHIFT=1 unless stated.)
- Reset, then start pulse -> next cycle: state INVULN, lives=3, ship_reset=1 for 1 cycle only, ship_visible=1.
- INVULN blink and expiry: 8 frame_ticks -> ship_visible pattern 1,1,0,0,1,1,0,0 per tick. After the 8th tick, state ALIVE and ship_visible=1.
- Hit during INVULN -> lives stays 3, no state change.
- Hit in ALIVE on the same cycle as frame_tick -> state EXPLODE, lives=2, explode_active=1, ship_visible=0, thrust_en=0 with thrust_btn=1. After exactly 4 ticks: RESPAWN with a ship_reset pulse. After 2 more ticks: INVULN.
- Three hits across lives -> after the third EXPLODE expiry, state GAMEOVER, game_over=1, lives=0, no ship_reset. Further hit pulses do nothing. start -> lives=3, state INVULN.
- Assert resetN=0 mid-EXPLODE with timer=2 -> immediately state IDLE, all outputs 0, lives=0. After release, no spurious ship_reset.
- Gap check: no frame_tick for 1000 cycles in EXPLODE -> timer and state unchanged.
